// File: rtl/axis_dual_boxcar_averager.sv
// axis_dual_boxcar_averager: averages blocks of 2^s signed sample pairs into one AXI-Stream result.
// Define AVG_ROUND_EN for round-half-up averaging; default is floor (arithmetic shift).
module axis_dual_boxcar_averager #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int MAX_SHIFT    = 12
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic [SAMPLE_WIDTH-1:0]   S_AXIS_S0_tdata,
    input  logic                      S_AXIS_S0_tvalid,
    input  logic [SAMPLE_WIDTH-1:0]   S_AXIS_S1_tdata,
    input  logic                      S_AXIS_S1_tvalid,
    input  logic                      enable,
    input  logic [3:0]                shift_cfg,
    output logic [2*SAMPLE_WIDTH-1:0] M_AXIS_AVG_tdata,
    output logic                      M_AXIS_AVG_tvalid,
    input  logic                      M_AXIS_AVG_tready,
    output logic [15:0]               overrun_count
);
    localparam int CW = MAX_SHIFT + 1;
    typedef enum logic {IDLE, ACC} state_t;
    state_t r_state;
    logic [3:0] r_s;
    logic [CW-1:0] r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc0, r_acc1, r_sum0, r_sum1;
    logic r_s1_valid, r_tvalid;
    logic [2*SAMPLE_WIDTH-1:0] r_tdata;
    logic [15:0] r_ovr;
    logic w_accept, w_last, w_free;
    logic [CW-1:0] w_nm1;
    logic [3:0] w_s_new;
    logic signed [ACC_WIDTH-1:0] w_add0, w_add1, w_bias;
    logic [SAMPLE_WIDTH-1:0] w_avg0, w_avg1;

    assign w_accept = (r_state == ACC) && enable && S_AXIS_S0_tvalid && S_AXIS_S1_tvalid;
    assign w_nm1    = (CW'(1) << r_s) - CW'(1);
    assign w_last   = r_cnt == w_nm1;
    assign w_free   = !r_tvalid || M_AXIS_AVG_tready;
    assign w_s_new  = (shift_cfg > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : shift_cfg;
    assign w_add0   = r_acc0 + {{(ACC_WIDTH-SAMPLE_WIDTH){S_AXIS_S0_tdata[SAMPLE_WIDTH-1]}}, S_AXIS_S0_tdata};
    assign w_add1   = r_acc1 + {{(ACC_WIDTH-SAMPLE_WIDTH){S_AXIS_S1_tdata[SAMPLE_WIDTH-1]}}, S_AXIS_S1_tdata};
`ifdef AVG_ROUND_EN
    assign w_bias   = (r_s == 4'd0) ? '0 : ACC_WIDTH'(1) << (r_s - 4'd1);
`else
    assign w_bias   = '0;
`endif
    // ACC_WIDTH headroom guarantees the biased sum cannot overflow
    assign w_avg0   = SAMPLE_WIDTH'((r_sum0 + w_bias) >>> r_s);
    assign w_avg1   = SAMPLE_WIDTH'((r_sum1 + w_bias) >>> r_s);

    assign M_AXIS_AVG_tdata  = r_tdata;
    assign M_AXIS_AVG_tvalid = r_tvalid;
    assign overrun_count     = r_ovr;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_cnt      <= '0;
            r_acc0     <= '0;
            r_acc1     <= '0;
            r_sum0     <= '0;
            r_sum1     <= '0;
            r_s1_valid <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_ovr      <= '0;
        end else begin
            r_s1_valid <= w_accept && w_last;
            if (w_accept && w_last) begin
                r_sum0 <= w_add0;
                r_sum1 <= w_add1;
            end
            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_acc0  <= '0;
                r_acc1  <= '0;
            end else begin
                if (r_state == IDLE) begin
                    r_state <= ACC;
                    r_s     <= w_s_new;
                end
                if (w_accept) begin
                    r_acc0 <= w_last ? '0 : w_add0;
                    r_acc1 <= w_last ? '0 : w_add1;
                    r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
                end
            end
            // a stalled consumer keeps the held result; the new one is dropped and counted
            if (r_s1_valid) begin
                if (w_free) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= {w_avg1, w_avg0};
                end else if (r_ovr != 16'hFFFF) begin
                    r_ovr <= r_ovr + 16'd1;
                end
            end else if (M_AXIS_AVG_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end
endmodule
